// File: rtl/branch_predictor_tournament.sv
// Tournament branch predictor: bimodal + gshare + per-PC chooser.
// Prediction is combinational; execute-stage resolution trains the tables,
// repairs speculative history and accumulates saturating statistics.
module branch_predictor_tournament #(
  parameter int unsigned INDEX_W = 7,
  parameter int unsigned HIST_W  = 7,
  parameter int unsigned PC_LSB  = 2,
  parameter int unsigned MODE    = 2,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pred_valid,
  input  logic [31:0]       pred_pc,
  output logic              pred_taken,
  output logic              pred_src,
  output logic [HIST_W-1:0] pred_ghr,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic [HIST_W-1:0] upd_ghr,
  input  logic              upd_pred,
  input  logic              upd_taken,
  output logic              mispredict,
  output logic [CNT_W-1:0]  cnt_branches,
  output logic [CNT_W-1:0]  cnt_correct,
  output logic [CNT_W-1:0]  cnt_bim_correct,
  output logic [CNT_W-1:0]  cnt_gsh_correct
);

  localparam int unsigned DEPTH = 1 << INDEX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]         bim_tbl [DEPTH];
  logic [1:0]         gsh_tbl [DEPTH];
  logic [1:0]         cho_tbl [DEPTH];
  logic [HIST_W-1:0]  spec_ghr;

  logic [INDEX_W-1:0] p_bi, p_gi, u_bi, u_gi;
  logic               p_bim_dir, p_gsh_dir, p_use_gsh;
  logic               u_bim_ok, u_gsh_ok, u_cho_train;
  logic               unused_pc_bits;

  // 2-bit saturating counter step toward the given direction
  function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    else    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  // Shift a new outcome into the history; for HIST_W=1 this is just the bit
  function automatic logic [HIST_W-1:0] hist_push(input logic [HIST_W-1:0] h, input logic b);
    return HIST_W'({h, b});
  endfunction

  // Statistics increment that sticks at all-ones
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  // Only the indexing slice of each PC matters; the rest is intentionally dropped
  assign unused_pc_bits = ^{pred_pc, upd_pc};

  assign p_bi = pred_pc[PC_LSB +: INDEX_W];
  assign p_gi = p_bi ^ INDEX_W'(spec_ghr);
  assign u_bi = upd_pc[PC_LSB +: INDEX_W];
  assign u_gi = u_bi ^ INDEX_W'(upd_ghr);

  assign pred_ghr   = spec_ghr;
  assign mispredict = upd_valid & (upd_pred ^ upd_taken);

  // Fetch-cycle direction and component select
  always_comb begin
    p_bim_dir  = bim_tbl[p_bi][1];
    p_gsh_dir  = gsh_tbl[p_gi][1];
    p_use_gsh  = 1'b0;
    pred_taken = 1'b0;
    pred_src   = 1'b0;
    if (MODE == 1)      p_use_gsh = 1'b1;
    else if (MODE == 2) p_use_gsh = cho_tbl[p_bi][1];
    if (pred_valid) begin
      pred_src   = p_use_gsh;
      pred_taken = p_use_gsh ? p_gsh_dir : p_bim_dir;
    end
  end

  // Component correctness from the table contents seen by the resolving branch
  always_comb begin
    u_bim_ok    = (bim_tbl[u_bi][1] == upd_taken);
    u_gsh_ok    = (gsh_tbl[u_gi][1] == upd_taken);
    u_cho_train = (MODE == 2) && (u_bim_ok != u_gsh_ok);
  end

  // Table training; reset restores weakly-not-taken / weakly-bimodal everywhere
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        bim_tbl[INDEX_W'(i)] <= 2'b01;
        gsh_tbl[INDEX_W'(i)] <= 2'b01;
        cho_tbl[INDEX_W'(i)] <= 2'b01;
      end
    end else if (upd_valid) begin
      bim_tbl[u_bi] <= sat2(bim_tbl[u_bi], upd_taken);
      gsh_tbl[u_gi] <= sat2(gsh_tbl[u_gi], upd_taken);
      if (u_cho_train) cho_tbl[u_bi] <= sat2(cho_tbl[u_bi], u_gsh_ok);
    end
  end

  // Speculative history: repair on mispredict wins over the fetch shift
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          spec_ghr <= '0;
    else if (mispredict) spec_ghr <= hist_push(upd_ghr, upd_taken);
    else if (pred_valid) spec_ghr <= hist_push(spec_ghr, pred_taken);
  end

  // Saturating accuracy statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_branches    <= '0;
      cnt_correct     <= '0;
      cnt_bim_correct <= '0;
      cnt_gsh_correct <= '0;
    end else if (upd_valid) begin
      cnt_branches <= sat_inc(cnt_branches);
      if (upd_pred == upd_taken) cnt_correct     <= sat_inc(cnt_correct);
      if (u_bim_ok)              cnt_bim_correct <= sat_inc(cnt_bim_correct);
      if (u_gsh_ok)              cnt_gsh_correct <= sat_inc(cnt_gsh_correct);
    end
  end

endmodule

// File: tb/tb_branch_predictor_tournament.sv
// Scoreboard bench for branch_predictor_tournament: three instances
// (tournament, bimodal-only, 3-bit statistics) driven from one sequence.
module tb_branch_predictor_tournament;

  localparam int A = 0, B = 10, C = 20;
  localparam int PT = 0, PS = 1, PG = 2, MP = 3, NB = 4, NC = 5, NBIM = 6, NGSH = 7, GAP = 8;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic clk, reset;

  logic        a_pv, a_pt, a_ps, a_uv, a_upred, a_utaken, a_mp;
  logic [31:0] a_pc, a_upc, a_nb, a_nc, a_nbim, a_ngsh;
  logic [6:0]  a_pg, a_ughr;
  logic        b_pv, b_pt, b_ps, b_uv, b_upred, b_utaken, b_mp;
  logic [31:0] b_pc, b_upc, b_nb, b_nc, b_nbim, b_ngsh;
  logic [6:0]  b_pg, b_ughr;
  logic        c_pv, c_pt, c_ps, c_uv, c_upred, c_utaken, c_mp;
  logic [31:0] c_pc, c_upc;
  logic [2:0]  c_nb, c_nc, c_nbim, c_ngsh;
  logic [6:0]  c_pg, c_ughr;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  branch_predictor_tournament #(.MODE(2)) u_a (
    .clk(clk), .reset(reset), .pred_valid(a_pv), .pred_pc(a_pc), .pred_taken(a_pt),
    .pred_src(a_ps), .pred_ghr(a_pg), .upd_valid(a_uv), .upd_pc(a_upc), .upd_ghr(a_ughr),
    .upd_pred(a_upred), .upd_taken(a_utaken), .mispredict(a_mp), .cnt_branches(a_nb),
    .cnt_correct(a_nc), .cnt_bim_correct(a_nbim), .cnt_gsh_correct(a_ngsh));

  branch_predictor_tournament #(.MODE(0)) u_b (
    .clk(clk), .reset(reset), .pred_valid(b_pv), .pred_pc(b_pc), .pred_taken(b_pt),
    .pred_src(b_ps), .pred_ghr(b_pg), .upd_valid(b_uv), .upd_pc(b_upc), .upd_ghr(b_ughr),
    .upd_pred(b_upred), .upd_taken(b_utaken), .mispredict(b_mp), .cnt_branches(b_nb),
    .cnt_correct(b_nc), .cnt_bim_correct(b_nbim), .cnt_gsh_correct(b_ngsh));

  branch_predictor_tournament #(.MODE(2), .CNT_W(3)) u_c (
    .clk(clk), .reset(reset), .pred_valid(c_pv), .pred_pc(c_pc), .pred_taken(c_pt),
    .pred_src(c_ps), .pred_ghr(c_pg), .upd_valid(c_uv), .upd_pc(c_upc), .upd_ghr(c_ughr),
    .upd_pred(c_upred), .upd_taken(c_utaken), .mispredict(c_mp), .cnt_branches(c_nb),
    .cnt_correct(c_nc), .cnt_bim_correct(c_nbim), .cnt_gsh_correct(c_ngsh));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time budget exceeded");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      A + PT:   obs = 32'(a_pt);
      A + PS:   obs = 32'(a_ps);
      A + PG:   obs = 32'(a_pg);
      A + MP:   obs = 32'(a_mp);
      A + NB:   obs = a_nb;
      A + NC:   obs = a_nc;
      A + NBIM: obs = a_nbim;
      A + NGSH: obs = a_ngsh;
      A + GAP:  obs = 32'((a_ngsh >= a_nbim) && ((a_ngsh - a_nbim) >= 32'd15));
      B + PT:   obs = 32'(b_pt);
      B + PS:   obs = 32'(b_ps);
      B + PG:   obs = 32'(b_pg);
      B + MP:   obs = 32'(b_mp);
      B + NB:   obs = b_nb;
      B + NC:   obs = b_nc;
      C + PT:   obs = 32'(c_pt);
      C + PS:   obs = 32'(c_ps);
      C + PG:   obs = 32'(c_pg);
      C + MP:   obs = 32'(c_mp);
      C + NB:   obs = 32'(c_nb);
      C + NC:   obs = 32'(c_nc);
      C + NBIM: obs = 32'(c_nbim);
      C + NGSH: obs = 32'(c_ngsh);
      default:  obs = 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Settle, drain all pending expectations against the DUTs, advance one cycle
  task automatic tick();
    exp_t e;
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, obs(e.sel), e.exp);
    end
    @(negedge clk);
  endtask

  task automatic clr_all();
    a_pv = 0; a_pc = '0; a_uv = 0; a_upc = '0; a_ughr = '0; a_upred = 0; a_utaken = 0;
    b_pv = 0; b_pc = '0; b_uv = 0; b_upc = '0; b_ughr = '0; b_upred = 0; b_utaken = 0;
    c_pv = 0; c_pc = '0; c_uv = 0; c_upc = '0; c_ughr = '0; c_upred = 0; c_utaken = 0;
  endtask

  initial begin
    logic       p;
    logic [6:0] g;
    clr_all();
    reset = 1'b0;
    @(negedge clk);

    // combinational outputs while reset is held
    c_pv = 1; c_pc = 32'h100; c_uv = 1; c_upred = 0; c_utaken = 1;
    expect_val("rst_mispredict", C + MP, 32'd1);
    expect_val("rst_pred_taken", C + PT, 32'd0);
    expect_val("rst_pred_src",   C + PS, 32'd0);
    expect_val("rst_pred_ghr",   C + PG, 32'd0);
    expect_val("rst_cnt_br",     C + NB, 32'd0);
    tick();
    clr_all();
    tick();
    reset = 1'b1;
    tick();

    // reset values, tournament instance
    a_pv = 1; a_pc = 32'h100;
    expect_val("t1_pred_taken", A + PT, 32'd0);
    expect_val("t1_pred_src",   A + PS, 32'd0);
    expect_val("t1_pred_ghr",   A + PG, 32'd0);
    expect_val("t1_cnt_br",     A + NB, 32'd0);
    expect_val("t1_cnt_ok",     A + NC, 32'd0);
    expect_val("t1_cnt_bim",    A + NBIM, 32'd0);
    expect_val("t1_cnt_gsh",    A + NGSH, 32'd0);
    tick();
    clr_all();

    // bimodal training, MODE 0
    b_uv = 1; b_upc = 32'h40; b_ughr = '0; b_upred = 0; b_utaken = 1;
    expect_val("t2_mp1", B + MP, 32'd1);
    tick();
    expect_val("t2_mp2", B + MP, 32'd1);
    expect_val("t2_br1", B + NB, 32'd1);
    tick();
    clr_all();
    b_pv = 1; b_pc = 32'h40;
    expect_val("t2_pred_taken", B + PT, 32'd1);
    expect_val("t2_pred_src",   B + PS, 32'd0);
    expect_val("t2_pred_ghr",   B + PG, 32'd1);
    expect_val("t2_cnt_br",     B + NB, 32'd2);
    expect_val("t2_cnt_ok",     B + NC, 32'd0);
    expect_val("t2_mp_idle",    B + MP, 32'd0);
    tick();

    // history shift T,T,NT then repair with a simultaneous fetch
    expect_val("t3_p1_taken", B + PT, 32'd1);
    expect_val("t3_p1_ghr",   B + PG, 32'h03);
    tick();
    expect_val("t3_p2_taken", B + PT, 32'd1);
    expect_val("t3_p2_ghr",   B + PG, 32'h07);
    tick();
    b_pc = 32'h44;
    expect_val("t3_p3_taken", B + PT, 32'd0);
    expect_val("t3_p3_ghr",   B + PG, 32'h0F);
    tick();
    clr_all();
    expect_val("t3_ghr_110", B + PG, 32'h1E);
    tick();
    b_pv = 1; b_pc = 32'h40;
    b_uv = 1; b_upc = 32'h40; b_ughr = '0; b_upred = 0; b_utaken = 1;
    expect_val("t3_rep_mp",    B + MP, 32'd1);
    expect_val("t3_rep_taken", B + PT, 32'd1);
    tick();
    clr_all();
    expect_val("t3_rep_ghr", B + PG, 32'd1);
    expect_val("t3_rep_br",  B + NB, 32'd3);
    tick();

    // statistics saturation with 3-bit counters
    for (int i = 0; i < 9; i++) begin
      c_uv = 1; c_upc = 32'h0; c_ughr = '0; c_upred = 0; c_utaken = 0;
      expect_val("t6_br_run", C + NB, 32'((i < 7) ? i : 7));
      expect_val("t6_mp",     C + MP, 32'd0);
      tick();
    end
    clr_all();
    expect_val("t6_cnt_br",  C + NB, 32'd7);
    expect_val("t6_cnt_ok",  C + NC, 32'd7);
    expect_val("t6_cnt_bim", C + NBIM, 32'd7);
    expect_val("t6_cnt_gsh", C + NGSH, 32'd7);
    tick();

    // same-cycle predict/update collision on one bimodal entry
    a_pv = 1; a_pc = 32'h20;
    a_uv = 1; a_upc = 32'h20; a_ughr = '0; a_upred = 0; a_utaken = 1;
    expect_val("t5_old_taken", A + PT, 32'd0);
    expect_val("t5_old_src",   A + PS, 32'd0);
    expect_val("t5_mp",        A + MP, 32'd1);
    tick();
    clr_all();
    a_pv = 1; a_pc = 32'h20;
    expect_val("t5_new_taken", A + PT, 32'd1);
    expect_val("t5_new_src",   A + PS, 32'd0);
    expect_val("t5_ghr",       A + PG, 32'd1);
    expect_val("t5_cnt_br",    A + NB, 32'd1);
    expect_val("t5_cnt_ok",    A + NC, 32'd0);
    tick();
    clr_all();

    // reset asserted while an update is pending discards it
    a_uv = 1; a_upc = 32'h80; a_upred = 0; a_utaken = 1;
    reset = 1'b0;
    expect_val("rst_mid_cnt_br", A + NB, 32'd0);
    expect_val("rst_mid_ghr",    A + PG, 32'd0);
    tick();
    clr_all();
    tick();
    reset = 1'b1;
    tick();
    expect_val("rst_mid_after_br", A + NB, 32'd0);
    tick();

    // alternating loop branch: gshare learns it, bimodal never does
    for (int k = 0; k < 40; k++) begin
      clr_all();
      a_pv = 1; a_pc = 32'h80;
      #2;
      p = a_pt;
      g = a_pg;
      @(negedge clk);
      clr_all();
      a_uv = 1; a_upc = 32'h80; a_ughr = g; a_upred = p; a_utaken = (k % 2 == 0);
      @(negedge clk);
    end
    clr_all();
    a_pv = 1; a_pc = 32'h80;
    expect_val("t4_pred_src",   A + PS, 32'd1);
    expect_val("t4_pred_taken", A + PT, 32'd1);
    expect_val("t4_pred_ghr",   A + PG, 32'h2A);
    expect_val("t4_cnt_br",     A + NB, 32'd40);
    expect_val("t4_cnt_bim",    A + NBIM, 32'd0);
    expect_val("t4_cnt_gsh",    A + NGSH, 32'd36);
    expect_val("t4_gap",        A + GAP, 32'd1);
    tick();
    clr_all();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predictor_tournament.md
# branch_predictor_tournament

Parametrised tournament branch predictor for the RISC-V core fetch stage. Combines a PC-indexed bimodal table, a gshare table indexed by PC XOR speculative global history, and a per-PC chooser. Prediction is combinational in the fetch cycle. Resolution from execute arrives later on a separate update port, together with the history snapshot issued at prediction time. On a mispredict the block repairs the speculative history and keeps saturating accuracy statistics.

## Interface
- `INDEX_W`, 7: table index width. Each of the three tables has 2^INDEX_W 2-bit entries.
- `HIST_W`, 7: global history length. Legal range is 1..INDEX_W.
- `PC_LSB`, 2: lowest PC bit used for indexing. Bits below it are ignored.
- `MODE`, 2: predictor selection. 0 = bimodal only, 1 = gshare only, 2 = tournament.
- `CNT_W`, 32: width of each statistics counter.

Ports:
- `clk`  in  1  clock. All state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pred_valid`  in  1  fetch holds a branch this cycle.
- `pred_pc`  in  32  PC of the branch being predicted.
- `pred_taken`  out  1  predicted direction. Combinational.
- `pred_src`  out  1  1 = gshare was chosen, 0 = bimodal was chosen. Combinational.
- `pred_ghr`  out  HIST_W  speculative history before this prediction's shift. Carried down the pipeline.
- `upd_valid`  in  1  a branch resolved in execute this cycle.
- `upd_pc`  in  32  PC of the resolved branch.
- `upd_ghr`  in  HIST_W  the `pred_ghr` value issued for that branch.
- `upd_pred`  in  1  the `pred_taken` value issued for that branch.
- `upd_taken`  in  1  actual outcome.
- `mispredict`  out  1  `upd_valid & (upd_pred != upd_taken)`. Combinational; used to flush fetch.
- `cnt_branches`  out  CNT_W  number of resolved branches.
- `cnt_correct`  out  CNT_W  number of resolved branches where `upd_pred` was correct.
- `cnt_bim_correct`  out  CNT_W  number of resolved branches where the bimodal component was correct.
- `cnt_gsh_correct`  out  CNT_W  number of resolved branches where the gshare component was correct.

## Operation
**Indices**
- bi = pc[PC_LSB+INDEX_W-1:PC_LSB].
- gi = bi XOR zero-extended ghr.
- The chooser is indexed by bi.
- Prediction computes bi/gi from `pred_pc` and the internal `spec_ghr`.
- Update computes bi/gi from `upd_pc` and `upd_ghr`.

**Counters**
- Each entry is a 2-bit saturating counter.
- Taken increments, saturating at 2'b11. Not-taken decrements, saturating at 2'b00.
- An entry predicts taken when its MSB is 1.

**Selection**
- MODE 0: `pred_taken` = bimodal MSB.
- MODE 1: `pred_taken` = gshare MSB.
- MODE 2: chooser MSB 1 selects gshare, otherwise bimodal.
- `pred_src` reflects the component actually used (constant 0 in MODE 0, constant 1 in MODE 1).

**Predict cycle outputs**
- When `pred_valid`=0, `pred_taken` and `pred_src` are 0.
- `pred_ghr` always equals `spec_ghr`.

**Update cycle** (`upd_valid`=1)
- The bimodal entry at bi and the gshare entry at gi train toward `upd_taken`, in every MODE.
- Component correctness is recomputed from the table contents at update time.
- Chooser, MODE 2 only, and only when the two components disagree: increment if gshare is correct, decrement if bimodal is correct.

**Speculative history** (priority order)
1. `mispredict`: spec_ghr <= {upd_ghr[HIST_W-2:0], upd_taken}. Any simultaneous `pred_valid` shift is discarded.
2. Otherwise, `pred_valid`: spec_ghr <= {spec_ghr[HIST_W-2:0], pred_taken}.
3. Otherwise spec_ghr holds.
- When HIST_W=1, the shifted value is just the new bit.

**Statistics**
- On each `upd_valid`, `cnt_branches` increments by 1.
- Each of the other counters increments by 1 when its condition holds.
- All counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- Reset (`reset`=0, asynchronous):
  - all bimodal and gshare entries = 2'b01 (weakly not-taken);
  - all chooser entries = 2'b01 (weakly bimodal);
  - spec_ghr = 0;
  - all statistics counters = 0.
- During reset, the combinational outputs evaluate from the reset state: `pred_taken`=0, `pred_src`=0 in MODE 0/2, `pred_ghr`=0, `mispredict` follows its inputs.
- Reset asserted mid-operation aborts any in-flight update. No partial table write survives.
- Prediction latency is 0 cycles. A table update takes effect on the edge ending the update cycle.
- Predict and update to the same entry in the same cycle: the prediction uses the pre-update value. The new value is visible the following cycle.
- No handshake or backpressure. Each valid is sampled every cycle with no stall.
- The pipeline distance between predict and update is arbitrary. Correctness relies only on `upd_ghr`/`upd_pred` being the values issued at prediction time.

## Test plan
1. **Reset values.** After reset release in MODE 2, pred_pc=0x100 with pred_valid=1 -> pred_taken=0, pred_src=0, pred_ghr=0, all counters 0.
2. **Bimodal training.** MODE 0, two updates at upd_pc=0x40 with taken=1 (upd_pred=0) -> mispredict=1 on both. Then predict 0x40 -> pred_taken=1, cnt_branches=2, cnt_correct=0.
3. **History shift and repair.** Three predictions giving taken,taken,not-taken -> spec_ghr=3'b110 (low bits). Then a mispredict update with upd_ghr=0, upd_taken=1, plus a simultaneous pred_valid -> spec_ghr=1 next cycle; the pred shift is ignored.
4. **Chooser.** MODE 2, loop branch alternating T/NT at PC 0x80 for 40 updates -> chooser at that index saturates to 2'b11, pred_src=1, and cnt_gsh_correct exceeds cnt_bim_correct by ≥15.
5. **Same-cycle collision.** Entry at 0x20 = 2'b01; predict 0x20 while updating 0x20 taken -> pred_taken=0 that cycle, pred_taken=1 the next cycle.
6. **Saturation.** CNT_W=3, 9 correct updates -> cnt_branches=7 and cnt_correct=7; there is no wrap to 0.
